// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is never entered; the FSM decodes it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder assembled from two half-adder cells and an OR gate.
// This is the single slice that the serial adder reuses for every bit.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha_ab (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha_ci (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  // Both half adders can never carry at once, so OR is a complete merge.
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands arrive in parallel over a valid/ready
// handshake, are added LSB-first one bit per clock through a single
// full_adder_bit slice, and the sum/carry leave in parallel over a second
// valid/ready handshake.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the output port ovf
// (two's-complement signed overflow, timed and held like cy).
//
// State | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one bit per cycle, exactly WIDTH cycles
// DONE  | out_valid high, sum/cy held until out_ready

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             c_q,      c_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cy_q,     cy_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,    ovf_d;
`else
  // Without overflow reporting the carry into the MSB is never captured.
`endif

  logic fa_s;
  logic fa_co;

  full_adder_bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State, datapath and result registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cy_q     <= cy_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    sum_d     = sum_q;
    cy_d      = cy_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      RUN: begin
        busy     = 1'b1;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        c_d      = fa_co;
        shadow_d = {fa_s, shadow_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // The port is only updated here, never bit-by-bit.
          state_d = DONE;
          sum_d   = {fa_s, shadow_q[WIDTH-1:1]};
          cy_d    = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on the last bit cycle.
          ovf_d   = c_q ^ fa_co;
`endif
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  assign sum = sum_q;
  assign cy  = cy_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;
  localparam int TMO = 50;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic [W-1:0] sum;
  logic         cy;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sum       (sum),
    .cy        (cy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands, waits for acceptance, then waits for out_valid.
  // lat is the number of edges after the accept edge until out_valid is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit keep_valid,
                        output int lat, output bit timeout);
    int n;
    timeout  = 1'b0;
    A        = a;
    B        = b;
    cin      = ci;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin
      tick();
      n++;
    end
    if (!in_ready) timeout = 1'b1;
    tick();
    if (!keep_valid) in_valid = 1'b0;
    else begin
      A   = W'($urandom);
      B   = W'($urandom);
      cin = 1'($urandom);
    end
    lat = 0;
    while (!out_valid && lat < TMO) begin
      tick();
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    cin       = 1'b0;
    tick();
    tick();
    checks++;
    if (sum !== 8'h00 || cy !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: sum=%h cy=%b ov=%b busy=%b ir=%b, want 00 0 0 0 1",
               sum, cy, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ir=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] va [3] = '{8'h03, 8'hFF, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h05, 8'h01, 8'h01};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [3] = '{8'h08, 8'h00, 8'h81};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL basic_timeout[%0d]: no out_valid within %0d cycles", i, TMO);
      end
      checks++;
      if (lat != W) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d edges, want %0d", i, lat, W);
      end
      checks++;
      if (sum !== es[i] || cy !== ec[i] || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_result[%0d]: sum=%h cy=%b busy=%b ir=%b, want %h %b 1 0",
                 i, sum, cy, busy, in_ready, es[i], ec[i]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf !== eo[i]) begin
        errors++;
        $display("FAIL basic_ovf[%0d]: got %b want %b", i, ovf, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unexpected x");
`endif
      take_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== es[i] || cy !== ec[i]) begin
        errors++;
        $display("FAIL basic_hold[%0d]: ov=%b ir=%b sum=%h cy=%b, want 0 1 %h %b",
                 i, out_valid, in_ready, sum, cy, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    bit bad;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, lat, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bp_timeout: no out_valid within %0d cycles", TMO);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || sum !== 8'h46 || cy !== 1'b0 || in_ready !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_stable: ov=%b sum=%h cy=%b ir=%b, want 1 46 0 0",
               out_valid, sum, cy, in_ready);
    end
    take_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ir=%b ov=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit to;
    A        = 8'hAA;
    B        = 8'h55;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy !== 1'b1 || sum !== 8'h46) begin
      errors++;
      $display("FAIL mid_run_state: busy=%b sum=%h, want 1 46", busy, sum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== 8'h00 || cy !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: sum=%h cy=%b ov=%b busy=%b ir=%b, want 00 0 0 0 1",
               sum, cy, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(8'h10, 8'h20, 1'b0, 1'b0, lat, to);
    checks++;
    if (to || lat != W || sum !== 8'h30 || cy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: to=%b lat=%0d sum=%h cy=%b, want 0 %0d 30 0",
               to, lat, sum, cy, W);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   full;
    int lat;
    bit to;
    int good = 0;
    int bad_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      run_op(a, b, c, 1'b1, lat, to);
      if (to || lat != W || sum !== full[W-1:0] || cy !== full[W]) begin
        bad_cnt++;
        if (bad_cnt <= 5)
          $display("FAIL b2b_op[%0d]: %h+%h+%b got sum=%h cy=%b lat=%0d, want %h %b %0d",
                   i, a, b, c, sum, cy, lat, full[W-1:0], full[W], W);
      end else begin
        good++;
      end
      // Handshake edge; in_valid stays high with fresh operands for the next op.
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (good != 1000) begin
      errors++;
      $display("FAIL b2b_count: %0d correct results, want 1000", good);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
